mem_ctrl_param: RTL and testbench
=================================

Name: mem_ctrl_param

Overview:
Parametrised, byte-addressable data memory for the multicycle processor. It replaces the fixed 64x16 array with a registered request/acknowledge interface, programmable wait states, and byte or full-word access. Byte loads are sign-extended, and misaligned or out-of-range accesses are flagged. It sits between the datapath memory-address/data registers and the control FSM, which waits on ack.

Parameters:
DATA_W, 16, word width in bits; multiple of 8, at least 16; LANES = DATA_W/8, LANE_BITS = clog2(LANES)
ADDR_W, 16, byte-address width
DEPTH, 64, number of words
WAIT_STATES, 0, extra cycles between request acceptance and access (0..15)
BYTE_SIGNED, 1, 1 = sign-extend byte loads; 0 = zero-extend

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request; sampled only in IDLE
we  input  1  1 = write, 0 = read; latched with req
size  input  1  1 = full word, 0 = byte
addr  input  ADDR_W  byte address; latched with req
wdata  input  DATA_W  write data; byte writes use wdata[7:0]
rdata  output  DATA_W  registered read data
ack  output  1  one-cycle completion pulse
busy  output  1  high from acceptance until the cycle after ack
err  output  1  valid only while ack=1; 1 = access rejected

Behaviour:
- Memory array: DEPTH x DATA_W. At time zero, word 0 = 16'h02F0 (zero-extended if DATA_W>16) and all other words = 0. Reset does not alter array contents.
- Word index = addr >> LANE_BITS. Lane = addr[LANE_BITS-1:0]. Byte lane k occupies bits [8k+7:8k].
- Reset (async, any state): state=IDLE, rdata=0, ack=0, busy=0, err=0, wait counter=0. A pending write is aborted and the array is unchanged.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req=1 at an edge:
  - Latch we, size, addr and wdata.
  - Set busy=1, load counter with WAIT_STATES, go to WAIT.
  - If req=0, stay in IDLE.
- WAIT:
  - While counter != 0: decrement and stay.
  - At the edge where counter == 0: perform the access, assert ack=1, go to RESP.
  - Error checks at this edge: a misaligned word access (size=1 and lane != 0) or an out-of-range access (word index >= DEPTH) performs no array access, sets err=1, and leaves rdata unchanged.
- Access rules:
  - Word write: the whole word is replaced.
  - Byte write: only the addressed lane is replaced with wdata[7:0]; other lanes keep their value.
  - Word read: rdata = word.
  - Byte read: rdata = selected byte, sign- or zero-extended per BYTE_SIGNED.
  - Writes leave rdata unchanged.
- RESP: ack=1 (err valid) for exactly this cycle. At the next edge: ack=0, err=0, busy=0, go to IDLE. req is ignored in WAIT and RESP; it is not queued.
- Latency: req sampled at edge N gives ack high after edge N+1+WAIT_STATES. With req held high, throughput is one access per WAIT_STATES+3 cycles.
- rdata holds its last value between accesses.
- Latched inputs: changes to addr, wdata, we or size after acceptance have no effect on the transaction in flight.

Test Plan:
1. Defaults, WAIT_STATES=2: reset, then read word addr 0x0000 with req at edge N -> ack=1 after edge N+3, rdata=0x02F0, err=0, busy high for 4 cycles.
2. Word write 0xA5C3 to 0x0004, then byte read 0x0004 -> rdata=0xFFC3; byte read 0x0005 -> 0xFFA5; with BYTE_SIGNED=0 -> 0x00C3 / 0x00A5.
3. Byte write 0x7E to 0x0005, then word read 0x0004 -> 0x7EC3 (low lane preserved).
4. Word read 0x0003 -> ack with err=1, rdata unchanged. Word write 0x1111 to 0x0080 (index 64) -> err=1. Byte write to 0x0081 -> err=1, and word 0 still reads 0x02F0.
5. Start word write 0x1234 to 0x0010, then assert reset during WAIT -> busy, ack and rdata immediately 0, no ack pulse. The next read of 0x0010 returns 0x0000.
6. req held high continuously, WAIT_STATES=2 -> ack pulses every 5 cycles. Changing addr or wdata while busy does not affect the in-flight access. DATA_W=32: byte write 0x9A to 0x0006 -> word 1 bits [23:16] = 0x9A.

Source files
------------

// File: rtl/mem_ctrl_param.sv
// Byte-addressable data memory with a req/ack handshake, programmable wait states,
// byte/word access with sign- or zero-extended byte loads and error flagging.
module mem_ctrl_param #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0,
   parameter int BYTE_SIGNED = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic              size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic              err
);
   localparam int LANES     = DATA_W / 8;
   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W     = 4;
   localparam logic [DATA_W-1:0] INIT_WORD0 = DATA_W'(16'h02F0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state_reg, state_next;

   logic [CNT_W-1:0]  cnt_reg;
   logic              we_reg;
   logic              size_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              ack_reg;
   logic              err_reg;
   logic              busy_reg;
   logic [DATA_W-1:0] mem_word_reg;

   logic [DATA_W-1:0] mem [DEPTH] = '{0: INIT_WORD0, default: '0};

   logic [ADDR_W-1:0]    word_idx;
   logic [LANE_BITS-1:0] lane;
   logic [IDX_W-1:0]     mem_idx;
   logic [IDX_W-1:0]     in_idx;
   logic                 accept;
   logic                 misaligned;
   logic                 out_of_range;
   logic                 access_fire;
   logic                 access_err;
   logic                 wr_fire;
   logic [7:0]           lane_byte  [LANES];
   logic [7:0]           lane_wdata [LANES];
   logic [LANES-1:0]     lane_we;
   logic [7:0]           byte_sel;
   logic                 sign_bit;
   logic [DATA_W-1:0]    load_value;

   assign accept       = (state_reg == IDLE) && req;
   assign word_idx     = addr_reg >> LANE_BITS;
   assign lane         = addr_reg[LANE_BITS-1:0];
   assign mem_idx      = word_idx[IDX_W-1:0];
   assign in_idx       = IDX_W'(addr >> LANE_BITS);
   assign out_of_range = {1'b0, word_idx} >= (ADDR_W+1)'(DEPTH);
   assign misaligned   = size_reg && (lane != '0);
   assign access_fire  = (state_reg == WAIT) && (cnt_reg == '0);
   assign access_err   = misaligned || out_of_range;
   assign wr_fire      = access_fire && we_reg && !access_err;

   // Per-lane byte views of the fetched word and per-lane write enables.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_byte[gi]  = mem_word_reg[8*gi +: 8];
         assign lane_we[gi]    = wr_fire && (size_reg || (lane == LANE_BITS'(gi)));
         assign lane_wdata[gi] = size_reg ? wdata_reg[8*gi +: 8] : wdata_reg[7:0];
      end
   endgenerate

   assign byte_sel   = lane_byte[lane];
   assign sign_bit   = (BYTE_SIGNED != 0) && byte_sel[7];
   assign load_value = size_reg ? mem_word_reg : {{(DATA_W-8){sign_bit}}, byte_sel};

   // Word is fetched at acceptance; no write can intervene before the access edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_word_reg <= mem[in_idx];
      end
      for (int k = 0; k < LANES; k++) begin
         if (lane_we[k]) begin
            mem[mem_idx][8*k +: 8] <= lane_wdata[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req) state_next = WAIT;
         WAIT:    if (cnt_reg == '0) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg   <= '0;
         we_reg    <= 1'b0;
         size_reg  <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  we_reg    <= we;
                  size_reg  <= size;
                  addr_reg  <= addr;
                  wdata_reg <= wdata;
                  cnt_reg   <= CNT_W'(WAIT_STATES);
                  busy_reg  <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else begin
                  ack_reg <= 1'b1;
                  err_reg <= access_err;
                  if (!access_err && !we_reg) begin
                     rdata_reg <= load_value;
                  end
               end
            end
            RESP: begin
               ack_reg  <= 1'b0;
               err_reg  <= 1'b0;
               busy_reg <= 1'b0;
            end
            default: begin
               ack_reg  <= 1'b0;
               err_reg  <= 1'b0;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign rdata = rdata_reg;
   assign ack   = ack_reg;
   assign err   = err_reg;
   assign busy  = busy_reg;

endmodule

// File: tb/tb_mem_ctrl_param.sv
// Scoreboard bench for mem_ctrl_param: three instances cover signed/unsigned byte
// loads, wait-state latency, error flagging, reset abort and a 32-bit word width.
module tb_mem_ctrl_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  req_v, we_v, size_v;
   logic [15:0] addr_v  [3];
   logic [31:0] wdata_v [3];
   logic [15:0] rdata0, rdata1;
   logic [31:0] rdata2;
   logic        ack0, ack1, ack2, busy0, busy1, busy2, err0, err1, err2;
   logic [2:0]  ack_v, busy_v, err_v;
   logic [31:0] rd_v [3];

   assign ack_v  = {ack2, ack1, ack0};
   assign busy_v = {busy2, busy1, busy0};
   assign err_v  = {err2, err1, err0};
   assign rd_v[0] = {16'h0000, rdata0};
   assign rd_v[1] = {16'h0000, rdata1};
   assign rd_v[2] = rdata2;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      string       nm;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int cyc, bc;

   mem_ctrl_param #(.DATA_W(16), .WAIT_STATES(2), .BYTE_SIGNED(1)) u0 (
      .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .size(size_v[0]),
      .addr(addr_v[0]), .wdata(wdata_v[0][15:0]), .rdata(rdata0), .ack(ack0),
      .busy(busy0), .err(err0));

   mem_ctrl_param #(.DATA_W(16), .WAIT_STATES(0), .BYTE_SIGNED(0)) u1 (
      .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .size(size_v[1]),
      .addr(addr_v[1]), .wdata(wdata_v[1][15:0]), .rdata(rdata1), .ack(ack1),
      .busy(busy1), .err(err1));

   mem_ctrl_param #(.DATA_W(32), .WAIT_STATES(1), .BYTE_SIGNED(1)) u2 (
      .clk(clk), .reset(reset), .req(req_v[2]), .we(we_v[2]), .size(size_v[2]),
      .addr(addr_v[2]), .wdata(wdata_v[2]), .rdata(rdata2), .ack(ack2),
      .busy(busy2), .err(err2));

   // Present a request for one edge, then scramble the inputs to prove they were latched.
   task automatic start(input int i, input logic w, input logic s,
                        input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      we_v[i] = w; size_v[i] = s; addr_v[i] = a; wdata_v[i] = d; req_v[i] = 1'b1;
      @(posedge clk);
      #1;
      req_v[i] = 1'b0; we_v[i] = ~w; size_v[i] = ~s; addr_v[i] = ~a; wdata_v[i] = ~d;
   endtask

   task automatic wait_ack(input int i, output int c, output int b);
      c = 0;
      b = 0;
      do begin
         @(negedge clk);
         c++;
         if (busy_v[i]) b++;
      end while (!ack_v[i] && c < 40);
   endtask

   task automatic xfer(input int i, input logic w, input logic s, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                       input string nm, output int c, output int b);
      exp_t e;
      sb.push_back('{exp_rd, exp_err, nm});
      start(i, w, s, a, d);
      wait_ack(i, c, b);
      e = sb.pop_front();
      $display("[%0t] u%0d %s: we=%b size=%b addr=%h rdata=%h err=%b cycles=%0d",
               $time, i, e.nm, w, s, a, rd_v[i], err_v[i], c);
      checks++;
      if (ack_v[i] !== 1'b1) begin
         errors++;
         $display("FAIL %s ack: got %b after %0d cycles, expected 1", e.nm, ack_v[i], c);
      end else begin
         checks++;
         if (rd_v[i] !== e.rd) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", e.nm, rd_v[i], e.rd);
         end
         checks++;
         if (err_v[i] !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", e.nm, err_v[i], e.err);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_v = '0; we_v = '0; size_v = '0;
      for (int i = 0; i < 3; i++) begin
         addr_v[i] = '0;
         wdata_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rd_v[i] !== 32'h0) begin errors++; $display("FAIL reset_rdata u%0d: got %h expected 0", i, rd_v[i]); end
         checks++;
         if (ack_v[i] !== 1'b0) begin errors++; $display("FAIL reset_ack u%0d: got %b expected 0", i, ack_v[i]); end
         checks++;
         if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_busy u%0d: got %b expected 0", i, busy_v[i]); end
         checks++;
         if (err_v[i] !== 1'b0) begin errors++; $display("FAIL reset_err u%0d: got %b expected 0", i, err_v[i]); end
      end
      reset = 1'b0;
   endtask

   task automatic test_read_latency();
      xfer(0, 1'b0, 1'b1, 16'h0000, 32'h0, 32'h02F0, 1'b0, "rd_word0", cyc, bc);
      checks++;
      if (cyc !== 4) begin errors++; $display("FAIL latency_ws2: got %0d expected 4", cyc); end
      checks++;
      if (bc !== 4) begin errors++; $display("FAIL busy_len_ws2: got %0d expected 4", bc); end
      @(negedge clk);
      checks++;
      if (busy_v[0] !== 1'b0 || ack_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL after_resp: got busy=%b ack=%b expected 0/0", busy_v[0], ack_v[0]);
      end
   endtask

   task automatic test_byte_read();
      xfer(0, 1'b1, 1'b1, 16'h0004, 32'hA5C3, 32'h02F0, 1'b0, "wr_A5C3", cyc, bc);
      xfer(0, 1'b0, 1'b0, 16'h0004, 32'h0, 32'hFFC3, 1'b0, "rdb_s_4", cyc, bc);
      xfer(0, 1'b0, 1'b0, 16'h0005, 32'h0, 32'hFFA5, 1'b0, "rdb_s_5", cyc, bc);
      xfer(1, 1'b1, 1'b1, 16'h0004, 32'hA5C3, 32'h0000, 1'b0, "wr_A5C3_u", cyc, bc);
      checks++;
      if (cyc !== 2) begin errors++; $display("FAIL latency_ws0: got %0d expected 2", cyc); end
      xfer(1, 1'b0, 1'b0, 16'h0004, 32'h0, 32'h00C3, 1'b0, "rdb_u_4", cyc, bc);
      xfer(1, 1'b0, 1'b0, 16'h0005, 32'h0, 32'h00A5, 1'b0, "rdb_u_5", cyc, bc);
   endtask

   task automatic test_byte_write();
      xfer(0, 1'b1, 1'b0, 16'h0005, 32'h007E, 32'hFFA5, 1'b0, "wrb_7E", cyc, bc);
      xfer(0, 1'b0, 1'b1, 16'h0004, 32'h0, 32'h7EC3, 1'b0, "rd_7EC3", cyc, bc);
   endtask

   task automatic test_errors();
      xfer(0, 1'b0, 1'b1, 16'h0003, 32'h0, 32'h7EC3, 1'b1, "rd_misal", cyc, bc);
      xfer(0, 1'b1, 1'b1, 16'h0080, 32'h1111, 32'h7EC3, 1'b1, "wr_oor", cyc, bc);
      xfer(0, 1'b1, 1'b0, 16'h0081, 32'h0055, 32'h7EC3, 1'b1, "wrb_oor", cyc, bc);
      xfer(0, 1'b0, 1'b0, 16'h007F, 32'h0, 32'h0000, 1'b0, "rdb_last", cyc, bc);
      xfer(0, 1'b0, 1'b1, 16'h0000, 32'h0, 32'h02F0, 1'b0, "rd_word0b", cyc, bc);
   endtask

   task automatic test_reset_abort();
      bit seen;
      start(0, 1'b1, 1'b1, 16'h0010, 32'h1234);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      $display("[%0t] u0 reset_abort: busy=%b ack=%b rdata=%h", $time, busy_v[0], ack_v[0], rd_v[0]);
      checks++;
      if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_v[0]); end
      checks++;
      if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", ack_v[0]); end
      checks++;
      if (rd_v[0] !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", rd_v[0]); end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack_v[0]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got ack pulse, expected none"); end
      xfer(0, 1'b0, 1'b1, 16'h0010, 32'h0, 32'h0000, 1'b0, "rd_aborted", cyc, bc);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int last_ack;
      int nacks;
      last_ack = -1;
      nacks = 0;
      @(negedge clk);
      we_v[0] = 1'b1; size_v[0] = 1'b1; addr_v[0] = 16'h0008; wdata_v[0] = 32'h5A5A; req_v[0] = 1'b1;
      sb.push_back('{32'h0000, 1'b0, "b2b_wr"});
      sb.push_back('{32'h5A5A, 1'b0, "b2b_rd"});
      sb.push_back('{32'h5A5A, 1'b1, "b2b_misal"});
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 1) begin
            we_v[0] = 1'b0; wdata_v[0] = 32'hFFFF;
         end
         if (k == 6) addr_v[0] = 16'h0003;
         if (k == 11) req_v[0] = 1'b0;
         if (ack_v[0]) begin
            nacks++;
            if (last_ack >= 0) begin
               checks++;
               if (k - last_ack != 5) begin
                  errors++;
                  $display("FAIL b2b_period: got %0d cycles expected 5", k - last_ack);
               end
            end
            last_ack = k;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_ack: got ack at cycle %0d, expected none", k);
            end else begin
               e = sb.pop_front();
               $display("[%0t] u0 %s: rdata=%h err=%b cycle=%0d", $time, e.nm, rd_v[0], err_v[0], k);
               if (rd_v[0] !== e.rd || err_v[0] !== e.err) begin
                  errors++;
                  $display("FAIL %s: got rdata=%h err=%b expected rdata=%h err=%b",
                           e.nm, rd_v[0], err_v[0], e.rd, e.err);
               end
            end
         end
      end
      checks++;
      if (nacks != 3) begin errors++; $display("FAIL b2b_count: got %0d acks expected 3", nacks); end
      sb.delete();
   endtask

   task automatic test_wide();
      xfer(2, 1'b1, 1'b0, 16'h0006, 32'h0000009A, 32'h00000000, 1'b0, "w32_wrb", cyc, bc);
      checks++;
      if (cyc !== 3) begin errors++; $display("FAIL latency_ws1: got %0d expected 3", cyc); end
      xfer(2, 1'b0, 1'b1, 16'h0004, 32'h0, 32'h009A0000, 1'b0, "w32_rd1", cyc, bc);
      xfer(2, 1'b0, 1'b0, 16'h0006, 32'h0, 32'hFFFFFF9A, 1'b0, "w32_rdb", cyc, bc);
      xfer(2, 1'b0, 1'b1, 16'h0002, 32'h0, 32'hFFFFFF9A, 1'b1, "w32_misal", cyc, bc);
      xfer(2, 1'b0, 1'b0, 16'h0100, 32'h0, 32'hFFFFFF9A, 1'b1, "w32_oor", cyc, bc);
      xfer(2, 1'b0, 1'b1, 16'h0000, 32'h0, 32'h000002F0, 1'b0, "w32_rd0", cyc, bc);
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_byte_read();
      test_byte_write();
      test_errors();
      test_reset_abort();
      test_back_to_back();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
